framebuf_arbiter: RTL and testbench
===================================

Name: framebuf_arbiter

Overview:
- Sequences and shares the single-port 640x480x8 image RAM between the camera capture path (writer) and the display scan-out path (reader).
- Buffers incoming camera pixels in a small FIFO and generates linear write addresses per frame.
- Gives reads priority, with a starvation guard for writes.
- Reports frame completion, overflow and aborted frames. Sits between the camera capture logic, the display timing logic and the image RAM.

Parameters:
- WORD_DEPTH, 307200, pixels per frame (640x480); also the RAM depth.
- ADDR_W, 24, RAM address width.
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 4, write-buffer entries (power of 2).
- STARVE_LIMIT, 8, consecutive read-granted cycles with a full FIFO before a write slot is forced.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- capture_en_i  in  1  arms capture of the next frame.
- cam_frame_start_i  in  1  one-cycle pulse marking the start of a camera frame.
- cam_valid_i  in  1  camera pixel valid.
- cam_data_i  in  DATA_W  camera pixel.
- cam_ready_o  out  1  FIFO not full.
- rd_req_i  in  1  display read request.
- rd_adr_i  in  ADDR_W  display read address.
- rd_gnt_o  out  1  read accepted this cycle (combinational from rd_req_i and the starvation state).
- rd_valid_o  out  1  read data valid.
- rd_dat_o  out  DATA_W  read data.
- ram_we_o  out  1  RAM write enable.
- ram_adr_o  out  ADDR_W  RAM address.
- ram_dat_o  out  DATA_W  RAM write data.
- ram_dat_i  in  DATA_W  RAM read data; synchronous read, 1-cycle latency.
- busy_o  out  1  high in CAPT or DRAIN.
- frame_done_o  out  1  one-cycle pulse when a complete frame has been written.
- overflow_o  out  1  sticky: a pixel was dropped in the current frame.
- abort_cnt_o  out  8  saturating count of aborted frames.

Behaviour:
- Reset: the following are 0 or IDLE:
  - state, FIFO pointers, write address, pixel count, starvation counter;
  - every output register: rd_valid_o, rd_dat_o, ram_we_o, ram_adr_o, ram_dat_o, frame_done_o, overflow_o, abort_cnt_o, busy_o.
- Reset mid-frame discards all buffered pixels with no frame_done_o pulse.
- FSM states IDLE, CAPT, DRAIN, DONE:
  - IDLE -> CAPT on cam_frame_start_i && capture_en_i. On entry: write address = 0, pixel count = 0, overflow_o cleared.
  - CAPT: push cam_data_i when cam_valid_i && !full. If cam_valid_i && full, drop the pixel and set overflow_o; the pixel count still increments.
  - CAPT -> DRAIN when pixel count reaches WORD_DEPTH. Pixels after that are ignored.
  - DRAIN -> DONE when the FIFO is empty and no write is pending.
  - DONE: frame_done_o = 1 for exactly one cycle, then IDLE.
  - cam_frame_start_i in CAPT or DRAIN: abort. Flush the FIFO, abort_cnt_o += 1 (saturating at 255), restart CAPT at address 0 if capture_en_i is high, otherwise go to IDLE.
  - In IDLE, cam_valid_i is ignored and cam_ready_o = 1.
- Arbitration, per cycle (ram_* outputs are registered):
  - Read slot: rd_gnt_o = rd_req_i && !force_wr. Next cycle: ram_we_o = 0, ram_adr_o = rd_adr_i.
  - Data return: rd_valid_o = 1 one cycle after ram_adr_o is presented, with rd_dat_o = ram_dat_i. Total rd_gnt_o -> rd_valid_o latency is 2 cycles.
  - Write slot: when there is no read slot and the FIFO is not empty, pop. Next cycle: ram_we_o = 1, ram_adr_o = write address, ram_dat_o = FIFO head; the write address then increments.
  - Dropped pixels do not consume addresses: the address advances only on actual writes, so overflow shifts the image; this is flagged by overflow_o.
  - Starvation counter: increments each cycle with FIFO full && rd_gnt_o, resets otherwise. At STARVE_LIMIT, force_wr = 1 for one cycle: the write is taken, rd_gnt_o = 0, and the counter clears.
  - Simultaneous push and pop on a full FIFO: the pop frees a slot, but full is evaluated before the pop, so the pixel is dropped.
- Address width: the write address never exceeds WORD_DEPTH-1. The pixel count is ADDR_W wide.

Decomposition:
- Shared package fb_pkg holds:
  - the FSM state enum (IDLE, CAPT, DRAIN, DONE);
  - constants FB_WIDTH = 640, FB_HEIGHT = 480, FB_DEPTH = FB_WIDTH*FB_HEIGHT.
- One sub-module, fb_wr_fifo: a synchronous FIFO with push, pop, full, empty and flush. The arbiter and FSM stay in framebuf_arbiter.

Test Plan:
- WORD_DEPTH = 16, capture_en_i = 1, frame start, then 16 pixels 0x00..0x0F with no reads -> 16 RAM writes at addresses 0..15 with matching data; frame_done_o pulses once; overflow_o = 0.
- rd_req_i held high with rd_adr_i = 5 while the camera streams -> rd_gnt_o is high for 8 cycles, then low for 1 forced write; rd_valid_o follows each grant by 2 cycles with the RAM data.
- rd_req_i held high, 12 consecutive camera pixels -> FIFO fills after 4 pixels; overflow_o = 1; the dropped pixels are never written.
- Frame start after 7 pixels of a 16-pixel frame -> FIFO flushed; abort_cnt_o = 1; the next write goes to address 0; no frame_done_o for the aborted frame.
- Assert rst_i during DRAIN with 3 entries buffered -> the following cycle: state IDLE, ram_we_o = 0, no frame_done_o, busy_o = 0.
- capture_en_i = 0, frame start plus pixels -> no RAM writes, remains IDLE, cam_ready_o = 1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and frame geometry for the frame-buffer arbiter.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fb_state_t;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

endpackage

// File: rtl/fb_wr_fifo.sv
// Camera pixel write buffer: push/pop FIFO with synchronous flush, head shown combinationally.
// Zero-latency head; pushes on a full FIFO are ignored (full is taken before any same-cycle pop).
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr_q;
  logic [PW:0]  rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_dat = mem[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr_q[PW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/framebuf_arbiter.sv
// Shares one single-port image RAM between camera capture (writes) and display scan-out (reads).
// Reads win (grant -> rd_valid_o in 2 cycles); a full FIFO starved for STARVE_LIMIT cycles forces one write.
module framebuf_arbiter
  import fb_pkg::*;
#(
  parameter int WORD_DEPTH   = FB_DEPTH,
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              capture_en_i,
  input  logic              cam_frame_start_i,
  input  logic              cam_valid_i,
  input  logic [DATA_W-1:0] cam_data_i,
  output logic              cam_ready_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_adr_i,
  output logic              rd_gnt_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_dat_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_dat_o,
  input  logic [DATA_W-1:0] ram_dat_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o,
  output logic [7:0]        abort_cnt_o
);

  localparam int                SW       = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(WORD_DEPTH - 1);

  fb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_adr_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [SW-1:0]     starve_q;
  logic              rd_pend_q;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head_dat;
  logic              active, abort, frame_start, restart;
  logic              capt_pix, push, pop, force_wr;

  assign active      = (state_q == CAPT) || (state_q == DRAIN);
  assign abort       = active && cam_frame_start_i;
  assign frame_start = (state_q == IDLE) && cam_frame_start_i && capture_en_i;
  assign restart     = frame_start || (abort && capture_en_i);

  // Every valid pixel in CAPT counts toward the frame, accepted or dropped.
  assign capt_pix    = (state_q == CAPT) && !abort && cam_valid_i;
  assign push        = capt_pix && !fifo_full;

  assign force_wr    = (starve_q == SW'(STARVE_LIMIT));
  assign rd_gnt_o    = rd_req_i && !force_wr;
  assign pop         = active && !abort && !rd_gnt_o && !fifo_empty;

  assign cam_ready_o = (state_q == IDLE) || !fifo_full;

  // RAM data arrives in the same cycle rd_valid_o rises, so it is passed through
  // gated rather than re-registered; this keeps grant-to-data at two cycles.
  assign rd_dat_o    = rd_valid_o ? ram_dat_i : '0;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (abort),
    .push     (push),
    .push_dat (cam_data_i),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (frame_start) state_d = CAPT;
      CAPT: begin
        if (abort)                                     state_d = capture_en_i ? CAPT : IDLE;
        else if (cam_valid_i && pix_cnt_q == LAST_ADR) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                         state_d = capture_en_i ? CAPT : IDLE;
        else if (fifo_empty && !ram_we_o)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      wr_adr_q     <= '0;
      pix_cnt_q    <= '0;
      starve_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_o   <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_adr_o    <= '0;
      ram_dat_o    <= '0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
      abort_cnt_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_o <= (state_d == DONE);
      busy_o       <= (state_d == CAPT) || (state_d == DRAIN);

      if (restart) begin
        wr_adr_q   <= '0;
        pix_cnt_q  <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (pop)      wr_adr_q  <= (wr_adr_q == LAST_ADR) ? '0 : wr_adr_q + 1'b1;
        if (capt_pix) pix_cnt_q <= pix_cnt_q + 1'b1;
        if (capt_pix && fifo_full) overflow_o <= 1'b1;
      end

      if (abort && abort_cnt_o != 8'hFF) abort_cnt_o <= abort_cnt_o + 8'd1;

      if (abort || force_wr)        starve_q <= '0;
      else if (fifo_full && rd_gnt_o) starve_q <= starve_q + 1'b1;
      else                          starve_q <= '0;

      if (rd_gnt_o) begin
        ram_we_o  <= 1'b0;
        ram_adr_o <= rd_adr_i;
      end else if (pop) begin
        ram_we_o  <= 1'b1;
        ram_adr_o <= wr_adr_q;
        ram_dat_o <= head_dat;
      end else begin
        ram_we_o  <= 1'b0;
      end

      rd_pend_q  <= rd_gnt_o;
      rd_valid_o <= rd_pend_q;
    end
  end

endmodule

// File: tb/tb_framebuf_arbiter.sv
// Directed bench for framebuf_arbiter with a 16-pixel frame and a behavioural synchronous RAM.
module tb_framebuf_arbiter;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cap_en, start, cam_valid;
  logic [7:0]  cam_data;
  logic        cam_ready;
  logic        rd_req;
  logic [23:0] rd_adr;
  logic        rd_gnt, rd_valid;
  logic [7:0]  rd_dat;
  logic        ram_we;
  logic [23:0] ram_adr;
  logic [7:0]  ram_wdat;
  logic [7:0]  ram_rdat;
  logic        busy, frame_done, overflow;
  logic [7:0]  abort_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [64];
  logic [23:0] log_adr [256];
  logic [7:0]  log_dat [256];
  int          wr_n = 0;
  int          done_n = 0;

  always #5 clk = ~clk;

  framebuf_arbiter #(
    .WORD_DEPTH   (16),
    .ADDR_W       (24),
    .DATA_W       (8),
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .capture_en_i      (cap_en),
    .cam_frame_start_i (start),
    .cam_valid_i       (cam_valid),
    .cam_data_i        (cam_data),
    .cam_ready_o       (cam_ready),
    .rd_req_i          (rd_req),
    .rd_adr_i          (rd_adr),
    .rd_gnt_o          (rd_gnt),
    .rd_valid_o        (rd_valid),
    .rd_dat_o          (rd_dat),
    .ram_we_o          (ram_we),
    .ram_adr_o         (ram_adr),
    .ram_dat_o         (ram_wdat),
    .ram_dat_i         (ram_rdat),
    .busy_o            (busy),
    .frame_done_o      (frame_done),
    .overflow_o        (overflow),
    .abort_cnt_o       (abort_cnt)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_adr[5:0]] <= ram_wdat;
    ram_rdat <= mem[ram_adr[5:0]];
  end

  always @(negedge clk) begin
    if (ram_we && wr_n < 256) begin
      log_adr[wr_n] <= ram_adr;
      log_dat[wr_n] <= ram_wdat;
      wr_n <= wr_n + 1;
    end
    if (frame_done) done_n <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || dut.state_q != IDLE) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase;
    logic e1, e2, eg;

    rst = 1'b1; cap_en = 1'b0; start = 1'b0; cam_valid = 1'b0; cam_data = '0;
    rd_req = 1'b0; rd_adr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_we",       32'(ram_we),     32'd0);
    chk("rst_adr",      32'(ram_adr),    32'd0);
    chk("rst_done",     32'(frame_done), 32'd0);
    chk("rst_ovf",      32'(overflow),   32'd0);
    chk("rst_abort",    32'(abort_cnt),  32'd0);
    chk("rst_rvalid",   32'(rd_valid),   32'd0);
    chk("rst_rdat",     32'(rd_dat),     32'd0);
    chk("rst_ready",    32'(cam_ready),  32'd1);
    tick();
    rst = 1'b0;

    // Full frame, no reads: sixteen writes in order.
    cap_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    base = wr_n; dbase = done_n;
    for (int i = 0; i < 16; i++) begin
      cam_valid = 1'b1; cam_data = 8'(i);
      tick();
    end
    cam_valid = 1'b0;
    wait_idle("t1_idle");
    chk("t1_wr_count", 32'(wr_n - base),    32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t1_adr", 32'(log_adr[base + i]), 32'(i));
      chk("t1_dat", 32'(log_dat[base + i]), 32'(i));
    end
    chk("t1_done", 32'(done_n - dbase), 32'd1);
    chk("t1_ovf",  32'(overflow),       32'd0);

    // Reads held during a 12-pixel burst: fill, drops, starvation-forced write.
    base = wr_n; dbase = done_n;
    rd_req = 1'b1; rd_adr = 24'd5;
    e1 = 1'b0; e2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      start     = (k == 0);
      cam_valid = (k >= 1 && k <= 12);
      cam_data  = 8'(8'h1F + k);
      @(negedge clk);
      eg = (k != 13);
      chk("t2_gnt",    32'(rd_gnt),   32'(eg));
      chk("t2_rvalid", 32'(rd_valid), 32'(e2));
      if (e2) chk("t2_rdat", 32'(rd_dat), 32'h05);
      if (k == 5)  chk("t3_ready_full", 32'(cam_ready), 32'd0);
      if (k == 13) chk("t2_rd_adr",     32'(ram_adr),   32'd5);
      if (k == 14) begin
        chk("t2_force_we",  32'(ram_we),   32'd1);
        chk("t2_force_adr", 32'(ram_adr),  32'd0);
        chk("t2_force_dat", 32'(ram_wdat), 32'h20);
      end
      e2 = e1; e1 = eg;
      tick();
    end
    start = 1'b0; cam_valid = 1'b0;
    chk("t3_ovf", 32'(overflow), 32'd1);
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cam_valid = 1'b1; cam_data = 8'(8'h40 + i);
      tick();
    end
    cam_valid = 1'b0;
    wait_idle("t3_idle");
    chk("t3_wr_count", 32'(wr_n - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_adr", 32'(log_adr[base + i]), 32'(i));
      chk("t3_dat", 32'(log_dat[base + i]), (i < 4) ? 32'(8'h20 + i) : 32'(8'h40 + i - 4));
    end
    chk("t3_done",     32'(done_n - dbase), 32'd1);
    chk("t3_ovf_held", 32'(overflow),       32'd1);

    // Abort after 7 pixels, then a complete restarted frame.
    base = wr_n; dbase = done_n;
    for (int k = 0; k < 9; k++) begin
      start     = (k == 0 || k == 8);
      cam_valid = (k >= 1 && k <= 7);
      cam_data  = 8'(8'h4F + k);
      tick();
    end
    start = 1'b0; cam_valid = 1'b0;
    @(negedge clk);
    chk("t4_abort_cnt", 32'(abort_cnt),       32'd1);
    chk("t4_no_done",   32'(done_n - dbase),  32'd0);
    chk("t4_restart",   32'(dut.state_q),     32'(CAPT));
    chk("t4_ovf_clr",   32'(overflow),        32'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      cam_valid = 1'b1; cam_data = 8'(8'h60 + i);
      tick();
    end
    cam_valid = 1'b0;
    wait_idle("t4_idle");
    chk("t4_wr_count",  32'(wr_n - base),       32'd22);
    chk("t4_last_abrt", 32'(log_dat[base + 5]), 32'h55);
    chk("t4_first_adr", 32'(log_adr[base + 6]), 32'd0);
    chk("t4_first_dat", 32'(log_dat[base + 6]), 32'h60);
    chk("t4_end_adr",   32'(log_adr[base + 21]), 32'd15);
    chk("t4_end_dat",   32'(log_dat[base + 21]), 32'h6F);
    chk("t4_done",      32'(done_n - dbase),    32'd1);

    // Reset while draining with three pixels still buffered.
    for (int k = 0; k < 17; k++) begin
      start     = (k == 0);
      cam_valid = (k >= 1);
      cam_data  = 8'(8'h6F + k);
      rd_req    = (k >= 15);
      tick();
    end
    start = 1'b0; cam_valid = 1'b0;
    @(negedge clk);
    chk("t5_drain",   32'(dut.state_q),        32'(DRAIN));
    chk("t5_buffer",  32'(dut.u_fifo.empty),   32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_req = 1'b0;
    base = wr_n; dbase = done_n;
    @(negedge clk);
    chk("t5_state",   32'(dut.state_q), 32'(IDLE));
    chk("t5_we",      32'(ram_we),      32'd0);
    chk("t5_busy",    32'(busy),        32'd0);
    chk("t5_done",    32'(frame_done),  32'd0);
    repeat (10) tick();
    chk("t5_no_wr",   32'(wr_n - base),    32'd0);
    chk("t5_no_done", 32'(done_n - dbase), 32'd0);
    chk("t5_abort",   32'(abort_cnt),      32'd0);

    // Capture disabled: frame start and pixels are ignored.
    cap_en = 1'b0;
    base = wr_n;
    for (int k = 0; k < 7; k++) begin
      start     = (k == 0);
      cam_valid = (k >= 1);
      cam_data  = 8'(8'h90 + k);
      @(negedge clk);
      chk("t6_ready", 32'(cam_ready), 32'd1);
      tick();
      chk("t6_state", 32'(dut.state_q), 32'(IDLE));
    end
    start = 1'b0; cam_valid = 1'b0;
    repeat (4) tick();
    chk("t6_no_wr", 32'(wr_n - base), 32'd0);
    chk("t6_busy",  32'(busy),        32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
